cbus_frame_tx: RTL

Parametrised Cbus link transmitter. Accepts one byte-wide AXI-Stream packet at a time, buffers it whole (store-and-forward), then emits a framed packet: preamble, 16-bit length, payload, CRC-8. The frame is striped MSB-first across `SYS_W` serial lanes. The block sits between the fabric AXI-Stream source and the lane output registers/OSERDES of an upper or lower Cbus port. It generalises the single-lane byte path with a lane count parameter, length/CRC framing, oversize rejection and a programmable inter-frame gap.

---
 rtl/cbus_frame_tx.sv | 238 +++++++++++++++++++++++
 1 files changed

// File: rtl/cbus_frame_tx.sv
// Cbus link transmitter: store-and-forward one AXI-Stream packet, then send it as
// preamble / 16-bit length / payload / CRC-8, striped MSB-first across SYS_W lanes.
module cbus_frame_tx #(
    parameter int          SYS_W    = 1,
    parameter int          MAX_LEN  = 256,
    parameter int          IFG      = 4,
    parameter logic [7:0]  PREAMBLE = 8'hD5
) (
    input  logic             tx_core_clk,
    input  logic             tx_core_resetn,
    input  logic [7:0]       s_axis_tdata,
    input  logic             s_axis_tvalid,
    input  logic             s_axis_tlast,
    output logic             s_axis_tready,
    output logic [SYS_W-1:0] tx_dout,
    output logic             tx_active,
    output logic             err_oversize,
    output logic [15:0]      frame_cnt,
    output logic [1:0]       o_dbg_state
);

    localparam int BPC   = 8 / SYS_W;
    localparam int SUB_W = (BPC > 1) ? $clog2(BPC) : 1;
    localparam int AW    = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    localparam logic [15:0]      MAX_LEN16 = 16'(MAX_LEN);
    localparam logic [7:0]       IFG8      = 8'(IFG);
    localparam logic [SUB_W-1:0] SUB_LAST  = SUB_W'(BPC - 1);

    typedef enum logic [1:0] {
        S_FILL = 2'd0,
        S_DROP = 2'd1,
        S_SEND = 2'd2,
        S_GAP  = 2'd3
    } state_t;

    typedef enum logic [2:0] {
        F_PRE    = 3'd0,
        F_LEN_HI = 3'd1,
        F_LEN_LO = 3'd2,
        F_PAY    = 3'd3,
        F_CRC    = 3'd4,
        F_DONE   = 3'd5
    } field_t;

    state_t            r_state;
    state_t            w_state_nxt;
    field_t            r_field;
    logic              r_tready;
    logic [15:0]       r_wr_ptr;
    logic [15:0]       r_rd_ptr;
    logic [15:0]       r_len;
    logic [7:0]        r_shift;
    logic [SUB_W-1:0]  r_sub;
    logic [7:0]        r_crc;
    logic [7:0]        r_gap_cnt;
    logic [SYS_W-1:0]  r_dout;
    logic              r_active;
    logic              r_err;
    logic [15:0]       r_frame_cnt;
    logic [7:0]        r_buf [0:MAX_LEN-1];

    logic              w_hs;
    logic              w_wr_en;
    logic              w_err_set;
    logic              w_send_start;
    logic              w_fill_entry;
    logic              w_crc_byte;
    logic [7:0]        w_buf_rd;
    logic [7:0]        w_cur_byte;

    // CRC-8, poly 0x07, init 0, MSB-first, no reflection, no final XOR.
    function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] c;
        c = crc ^ data;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
        end
        return c;
    endfunction

    // Handshake: a byte transfers on a rising edge where s_axis_tvalid and
    // s_axis_tready are both high; tready never depends on tvalid.
    assign w_hs = s_axis_tvalid & r_tready;

    always_comb begin
        w_state_nxt  = r_state;
        w_wr_en      = 1'b0;
        w_err_set    = 1'b0;
        case (r_state)
            S_FILL: begin
                if (w_hs) begin
                    if (r_wr_ptr == MAX_LEN16) begin
                        if (s_axis_tlast) begin
                            w_err_set = 1'b1;
                        end else begin
                            w_state_nxt = S_DROP;
                        end
                    end else begin
                        w_wr_en = 1'b1;
                        if (s_axis_tlast) begin
                            w_state_nxt = S_SEND;
                        end
                    end
                end
            end
            S_DROP: begin
                if (w_hs && s_axis_tlast) begin
                    w_err_set   = 1'b1;
                    w_state_nxt = S_FILL;
                end
            end
            S_SEND: begin
                if (r_field == F_DONE) begin
                    w_state_nxt = (IFG8 == 8'd0) ? S_FILL : S_GAP;
                end
            end
            S_GAP: begin
                if (r_gap_cnt == 8'd0) begin
                    w_state_nxt = S_FILL;
                end
            end
            default: w_state_nxt = S_FILL;
        endcase
    end

    assign w_send_start = (r_state == S_FILL) && (w_state_nxt == S_SEND);
    assign w_fill_entry = (w_state_nxt == S_FILL) && (r_state != S_FILL);
    assign w_buf_rd     = r_buf[r_rd_ptr[AW-1:0]];
    assign w_crc_byte   = (r_field == F_LEN_HI) || (r_field == F_LEN_LO) || (r_field == F_PAY);

    always_comb begin
        w_cur_byte = 8'h00;
        case (r_field)
            F_PRE:    w_cur_byte = PREAMBLE;
            F_LEN_HI: w_cur_byte = r_len[15:8];
            F_LEN_LO: w_cur_byte = r_len[7:0];
            F_PAY:    w_cur_byte = w_buf_rd;
            F_CRC:    w_cur_byte = r_crc;
            default:  w_cur_byte = 8'h00;
        endcase
    end

    always_ff @(posedge tx_core_clk) begin
        if (w_wr_en) begin
            r_buf[r_wr_ptr[AW-1:0]] <= s_axis_tdata;
        end
    end

    always_ff @(posedge tx_core_clk or negedge tx_core_resetn) begin
        if (!tx_core_resetn) begin
            r_state     <= S_FILL;
            r_tready    <= 1'b0;
            r_err       <= 1'b0;
            r_wr_ptr    <= 16'd0;
            r_len       <= 16'd0;
        end else begin
            r_state  <= w_state_nxt;
            r_tready <= (w_state_nxt == S_FILL) || (w_state_nxt == S_DROP);
            r_err    <= w_err_set;
            if (w_err_set || w_fill_entry) begin
                r_wr_ptr <= 16'd0;
            end else if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + 16'd1;
            end
            if (w_send_start) begin
                r_len <= r_wr_ptr + 16'd1;
            end
        end
    end

    // Each byte is loaded into the shifter on sub-cycle 0, so the CRC folds in
    // covered bytes one byte ahead of the CRC slot and no bubble is needed.
    always_ff @(posedge tx_core_clk or negedge tx_core_resetn) begin
        if (!tx_core_resetn) begin
            r_field     <= F_PRE;
            r_sub       <= '0;
            r_rd_ptr    <= 16'd0;
            r_shift     <= 8'h00;
            r_crc       <= 8'h00;
            r_gap_cnt   <= 8'd0;
            r_dout      <= '0;
            r_active    <= 1'b0;
            r_frame_cnt <= 16'd0;
        end else if (w_send_start) begin
            r_field  <= F_PRE;
            r_sub    <= '0;
            r_rd_ptr <= 16'd0;
            r_crc    <= 8'h00;
        end else if (r_state == S_SEND) begin
            if (r_field == F_DONE) begin
                r_active    <= 1'b0;
                r_dout      <= '0;
                r_frame_cnt <= r_frame_cnt + 16'd1;
                r_gap_cnt   <= IFG8 - 8'd1;
            end else begin
                r_active <= 1'b1;
                if (r_sub == '0) begin
                    r_dout  <= w_cur_byte[7 -: SYS_W];
                    r_shift <= w_cur_byte << SYS_W;
                    if (w_crc_byte) begin
                        r_crc <= crc8_byte(r_crc, w_cur_byte);
                    end
                end else begin
                    r_dout  <= r_shift[7 -: SYS_W];
                    r_shift <= r_shift << SYS_W;
                end
                if (r_sub == SUB_LAST) begin
                    r_sub <= '0;
                    case (r_field)
                        F_PRE:    r_field <= F_LEN_HI;
                        F_LEN_HI: r_field <= F_LEN_LO;
                        F_LEN_LO: r_field <= F_PAY;
                        F_PAY: begin
                            r_rd_ptr <= r_rd_ptr + 16'd1;
                            if (r_rd_ptr == r_len - 16'd1) begin
                                r_field <= F_CRC;
                            end
                        end
                        default:  r_field <= F_DONE;
                    endcase
                end else begin
                    r_sub <= r_sub + 1'b1;
                end
            end
        end else if ((r_state == S_GAP) && (r_gap_cnt != 8'd0)) begin
            r_gap_cnt <= r_gap_cnt - 8'd1;
        end
    end

    assign s_axis_tready = r_tready;
    assign tx_dout       = r_dout;
    assign tx_active     = r_active;
    assign err_oversize  = r_err;
    assign frame_cnt     = r_frame_cnt;
    assign o_dbg_state   = r_state;

endmodule
